// File: rtl/rec_pkg.sv
// Shared definitions for the window reconstruction block.
// Holds the FSM state encoding and the field layout of the image and vector FIFO words.
// The vector field constants describe the default 14-bit address layout and are shared
// with the search block's packing logic.
package rec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PX_WAIT,
        PX_WRITE,
        VEC_WAIT,
        VEC_READ,
        VEC_LAT,
        VEC_WRITE,
        FINISH
    } rec_state_e;

    localparam int unsigned PIX_W = 24;

    // Image FIFO word: {tag[1:0], pixel[23:0]}
    localparam int unsigned IMG_TAG_MSB = 25;
    localparam int unsigned IMG_TAG_LSB = 24;

    // Vector FIFO word: {tag[1:0], ref[MSBI:0], act[MSBI:0]} for the default MSBI
    localparam int unsigned DEF_MSBI = 13;
    localparam int unsigned TAG_MSB  = 2 * DEF_MSBI + 3;
    localparam int unsigned TAG_LSB  = 2 * DEF_MSBI + 2;
    localparam int unsigned REF_MSB  = 2 * DEF_MSBI + 1;
    localparam int unsigned REF_LSB  = DEF_MSBI + 1;
    localparam int unsigned ACT_MSB  = DEF_MSBI;
    localparam int unsigned ACT_LSB  = 0;

endpackage

// File: rtl/rec_vec_unpack.sv
// Splits a vector FIFO word into tag, reference and actual addresses.
// Optional macro VEC_BOUNDS_EN: also flags whether both addresses fall inside the window.
// Ports:
//   vec_q_i     vector FIFO word {tag, ref, act}
//   limit_i     window size in pixels (VEC_BOUNDS_EN only)
//   in_bounds_o both addresses below limit_i (VEC_BOUNDS_EN only)
//   tag_o       frame tag
//   ref_o       source address of the copy
//   act_o       destination address of the copy
module rec_vec_unpack #(
    parameter int unsigned MSBI = 13
) (
    input  logic [2*MSBI+3:0] vec_q_i,
`ifdef VEC_BOUNDS_EN
    input  logic [MSBI:0]     limit_i,
    output logic              in_bounds_o,
`endif
    output logic [1:0]        tag_o,
    output logic [MSBI:0]     ref_o,
    output logic [MSBI:0]     act_o
);

    assign tag_o = vec_q_i[2*MSBI+3 -: 2];
    assign ref_o = vec_q_i[2*MSBI+1 -: MSBI+1];
    assign act_o = vec_q_i[MSBI:0];

`ifdef VEC_BOUNDS_EN
    assign in_bounds_o = (ref_o < limit_i) && (act_o < limit_i);
`endif

endmodule

// File: rtl/reconstruccion_ventana.sv
// Rebuilds the motion-estimation search window into a frame RAM.
// Phase 1 streams window_limit tagged pixels from the image FIFO to RAM[0..limit-1];
// phase 2 applies each tagged vector as RAM[act] <= RAM[ref] until the vector FIFO is empty.
// Entries whose tag differs from cont_img are popped and dropped, setting sticky tag_err.
// Optional macro VEC_BOUNDS_EN: vectors addressing outside the window are dropped and
// counted in bnd_err_cnt (saturating).
// Ports:
//   clk_fsm, rst_n       clock, asynchronous active-low reset
//   start, cont_img      start pulse (honoured in IDLE) and expected frame tag
//   window_limit         number of pixels in the window
//   idle, finish         IDLE indicator, one-cycle completion pulse
//   tag_err              sticky wrong-tag indicator, cleared on start
//   bnd_err_cnt          out-of-window vector drops (VEC_BOUNDS_EN only)
//   img_*, vec_*         show-ahead FIFO interfaces
//   ram_*                frame RAM port, read data valid RAM_LAT cycles after address
module reconstruccion_ventana #(
    parameter int unsigned MSBI    = 13,
    parameter int unsigned PIX_W   = 24,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              clk_fsm,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        cont_img,
    input  logic [MSBI:0]     window_limit,
    output logic              idle,
    output logic              finish,
    output logic              tag_err,
`ifdef VEC_BOUNDS_EN
    output logic [15:0]       bnd_err_cnt,
`endif
    input  logic              img_empty,
    input  logic [25:0]       img_q,
    output logic              img_rd_req,
    input  logic              vec_empty,
    input  logic [2*MSBI+3:0] vec_q,
    output logic              vec_rd_req,
    output logic [MSBI:0]     ram_addr,
    output logic              ram_wr_en,
    output logic [PIX_W-1:0]  ram_wdata,
    input  logic [PIX_W-1:0]  ram_rdata
);

    rec_pkg::rec_state_e state_q, state_d;
    logic [MSBI:0] px_q, px_d;
    logic [MSBI:0] lim_q, lim_d;
    logic [MSBI:0] ref_q, ref_d;
    logic [MSBI:0] act_q, act_d;
    logic [1:0]    lat_q, lat_d;
    logic          tag_err_q, tag_err_d;
`ifdef VEC_BOUNDS_EN
    logic [15:0]   bnd_q, bnd_d;
    logic          v_in_bounds;
`endif

    logic [1:0]    img_tag;
    logic [1:0]    v_tag;
    logic [MSBI:0] v_ref;
    logic [MSBI:0] v_act;
    logic [MSBI:0] px_inc;

    assign img_tag = img_q[rec_pkg::IMG_TAG_MSB:rec_pkg::IMG_TAG_LSB];
    assign px_inc  = px_q + 1'b1;

    rec_vec_unpack #(
        .MSBI (MSBI)
    ) u_vec_unpack (
        .vec_q_i     (vec_q),
`ifdef VEC_BOUNDS_EN
        .limit_i     (lim_q),
        .in_bounds_o (v_in_bounds),
`endif
        .tag_o       (v_tag),
        .ref_o       (v_ref),
        .act_o       (v_act)
    );

    always_ff @(posedge clk_fsm or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= rec_pkg::IDLE;
            px_q      <= '0;
            lim_q     <= '0;
            ref_q     <= '0;
            act_q     <= '0;
            lat_q     <= '0;
            tag_err_q <= 1'b0;
`ifdef VEC_BOUNDS_EN
            bnd_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            px_q      <= px_d;
            lim_q     <= lim_d;
            ref_q     <= ref_d;
            act_q     <= act_d;
            lat_q     <= lat_d;
            tag_err_q <= tag_err_d;
`ifdef VEC_BOUNDS_EN
            bnd_q     <= bnd_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        px_d       = px_q;
        lim_d      = lim_q;
        ref_d      = ref_q;
        act_d      = act_q;
        lat_d      = lat_q;
        tag_err_d  = tag_err_q;
`ifdef VEC_BOUNDS_EN
        bnd_d      = bnd_q;
`endif
        idle       = 1'b0;
        finish     = 1'b0;
        img_rd_req = 1'b0;
        vec_rd_req = 1'b0;
        ram_addr   = '0;
        ram_wr_en  = 1'b0;
        ram_wdata  = '0;

        unique case (state_q)
            rec_pkg::IDLE: begin
                idle = 1'b1;
                if (start) begin
                    tag_err_d = 1'b0;
                    px_d      = '0;
                    lim_d     = window_limit;
`ifdef VEC_BOUNDS_EN
                    bnd_d     = '0;
`endif
                    state_d   = (window_limit == '0) ? rec_pkg::VEC_WAIT : rec_pkg::PX_WAIT;
                end
            end

            rec_pkg::PX_WAIT: begin
                if (!img_empty) begin
                    if (img_tag == cont_img) begin
                        state_d = rec_pkg::PX_WRITE;
                    end else begin
                        img_rd_req = 1'b1;
                        tag_err_d  = 1'b1;
                    end
                end
            end

            // Entered only with a matching entry at the FIFO head, so the pop is safe.
            rec_pkg::PX_WRITE: begin
                ram_addr   = px_q;
                ram_wdata  = img_q[PIX_W-1:0];
                ram_wr_en  = 1'b1;
                img_rd_req = 1'b1;
                px_d       = px_inc;
                state_d    = (px_inc == lim_q) ? rec_pkg::VEC_WAIT : rec_pkg::PX_WAIT;
            end

            // All vectors precede the pixel dump, so empty here means the frame is done.
            rec_pkg::VEC_WAIT: begin
                if (vec_empty) begin
                    state_d = rec_pkg::FINISH;
                end else begin
                    vec_rd_req = 1'b1;
                    if (v_tag != cont_img) begin
                        tag_err_d = 1'b1;
`ifdef VEC_BOUNDS_EN
                    end else if (!v_in_bounds) begin
                        if (bnd_q != 16'hFFFF) begin
                            bnd_d = bnd_q + 16'd1;
                        end
`endif
                    end else begin
                        ref_d   = v_ref;
                        act_d   = v_act;
                        state_d = rec_pkg::VEC_READ;
                    end
                end
            end

            rec_pkg::VEC_READ: begin
                ram_addr = ref_q;
                lat_d    = 2'd1;
                state_d  = rec_pkg::VEC_LAT;
            end

            // Address held on ref so rdata in VEC_WRITE reflects RAM[ref] for either latency.
            rec_pkg::VEC_LAT: begin
                ram_addr = ref_q;
                if (lat_q == 2'(RAM_LAT)) begin
                    state_d = rec_pkg::VEC_WRITE;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end

            rec_pkg::VEC_WRITE: begin
                ram_addr  = act_q;
                ram_wdata = ram_rdata;
                ram_wr_en = 1'b1;
                state_d   = rec_pkg::VEC_WAIT;
            end

            rec_pkg::FINISH: begin
                finish  = 1'b1;
                state_d = rec_pkg::IDLE;
            end

            default: state_d = rec_pkg::IDLE;
        endcase
    end

    assign tag_err = tag_err_q;
`ifdef VEC_BOUNDS_EN
    assign bnd_err_cnt = bnd_q;
`endif

endmodule

// File: doc/reconstruccion_ventana.md
Name: reconstruccion_ventana

Overview:
Receiving end of the motion-estimation search stream. It drains the HPS-side image FIFO (26-bit {tag, pixel}) and vector FIFO (30-bit {tag, ref, act}) and rebuilds the search window into a frame RAM.
- Phase 1 writes window_limit pixels sequentially.
- Phase 2 applies each vector as a copy RAM[act] <= RAM[ref].
- The encoder emits all vectors before its pixel dump, so once phase 1 completes every vector is already queued. An empty vector FIFO therefore terminates phase 2.

Parameters:
MSBI, 13, MSB index of window address (address width MSBI+1)
PIX_W, 24, pixel width (RGB888)
RAM_LAT, 1, frame-RAM read latency in cycles (1 or 2)

Ports:
clk_fsm  in  1  system clock, all logic rising-edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse, begin reconstruction (ignored unless idle)
cont_img  in  2  expected frame tag
window_limit  in  MSBI+1  number of pixels in window
idle  out  1  high in IDLE
finish  out  1  one-cycle pulse on completion
tag_err  out  1  sticky; set when an entry with wrong tag is dropped; cleared on start
img_empty  in  1  image FIFO empty (show-ahead)
img_q  in  26  {tag[1:0], pixel[23:0]}
img_rd_req  out  1  pop image FIFO
vec_empty  in  1  vector FIFO empty (show-ahead)
vec_q  in  2*MSBI+4  {tag[1:0], ref[MSBI:0], act[MSBI:0]}
vec_rd_req  out  1  pop vector FIFO
ram_addr  out  MSBI+1  frame RAM address (read and write)
ram_wr_en  out  1  frame RAM write enable
ram_wdata  out  PIX_W  frame RAM write data
ram_rdata  in  PIX_W  frame RAM read data, valid RAM_LAT cycles after ram_addr

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, idle=1. All other outputs are 0: finish, tag_err, rd_reqs, ram_wr_en, ram_addr, ram_wdata. The pixel counter is 0. Reset mid-operation abandons the frame with no further FIFO pops.
- The FIFOs are show-ahead: q is valid whenever !empty. rd_req is asserted for exactly one cycle per consumed entry and never while empty.
- States:
  - IDLE: on start, clear tag_err and pixel counter px=0. If window_limit==0 go to VEC_WAIT; otherwise go to PX_WAIT.
  - PX_WAIT: wait for !img_empty.
    - Tag==cont_img: go to PX_WRITE.
    - Tag mismatch: pop, set tag_err, stay (pixel counter unchanged).
  - PX_WRITE: ram_addr=px, ram_wdata=img_q[23:0], ram_wr_en=1, img_rd_req=1, px<=px+1. If px+1==window_limit go to VEC_WAIT; otherwise go to PX_WAIT.
  - VEC_WAIT: if vec_empty go to FINISH.
    - Tag mismatch: pop, set tag_err, stay.
    - Tag match: latch ref/act, pop, go to VEC_READ.
  - VEC_READ: ram_addr=ref. Wait RAM_LAT cycles (VEC_LAT), then go to VEC_WRITE.
  - VEC_WRITE: ram_addr=act, ram_wdata=ram_rdata, ram_wr_en=1, go to VEC_WAIT.
  - FINISH: finish=1 for one cycle, go to IDLE.
- Throughput:
  - Phase 1: 2 cycles/pixel with the FIFO non-empty.
  - Phase 2: 3+RAM_LAT cycles/vector.
- Vector with ref==act: still performs the read/write (idempotent).
- Address counter width is MSBI+1; no wrap, since px stops at window_limit.
- start while not idle: ignored.
- A pixel entry arriving after the phase-1 count is reached is left in the FIFO for the next frame.

Optional Feature:
VEC_BOUNDS_EN
- Defined: in VEC_WAIT, a tag-matching vector with ref>=window_limit or act>=window_limit is popped and dropped without a RAM access. The out port bnd_err_cnt[15:0] (saturating; cleared on start; reset 0) increments per drop.
- Undefined: the port is absent, and all tag-matching vectors are applied unchecked (addresses used modulo 2^(MSBI+1)).

Decomposition:
Shared package rec_pkg holds:
- state encoding enum: IDLE, PX_WAIT, PX_WRITE, VEC_WAIT, VEC_READ, VEC_LAT, VEC_WRITE, FINISH
- field-slice constants: TAG_MSB/LSB, REF_MSB/LSB, ACT_MSB/LSB, PIX_W
These constants are shared with the search block's packing.

One natural sub-module, rec_vec_unpack, splits vec_q into tag/ref/act and does the bounds check (used under VEC_BOUNDS_EN).

Test Plan:
- window_limit=4, cont_img=2, img FIFO {2,A},{2,B},{2,C},{2,D}, vec FIFO empty -> writes A..D at addr 0..3 on consecutive PX_WRITE cycles; finish pulse; tag_err=0.
- Same pixels plus vectors (ref=1,act=3),(ref=0,act=2) -> final RAM = A,B,A,B; exactly 2 vec pops.
- Image FIFO holding {1,X} before the 4 valid pixels -> X dropped, tag_err=1, RAM holds A..D at 0..3.
- img_empty toggled every other cycle during phase 1 -> no pop or write while empty; same final RAM contents.
- rst_n pulled low during VEC_LAT -> outputs 0 immediately; idle=1; no write issued; next start runs cleanly.
- VEC_BOUNDS_EN, window_limit=4, vector (ref=5,act=1) -> no RAM write, bnd_err_cnt=1, RAM[1] unchanged.
